// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// behind a start/done valid-ready handshake. Result and borrow-out hold after
// the consumer takes them until the next operation is accepted.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic              ovf_q, ovf_d;
`endif

    logic a_bit, b_bit, d_bit, br_next;

    // Full-subtractor cell on the current LSB of the operand shift registers.
    always_comb begin
        a_bit   = a_q[0];
        b_bit   = b_q[0];
        d_bit   = a_bit ^ b_bit ^ br_q;
        br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    end

    // Next-state logic: accept in idle, shift one bit per run cycle, wait for consumer in done.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = StRun;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            StRun: begin
                a_d               = a_q >> 1;
                b_d               = b_q >> 1;
                br_d              = br_next;
                // Result enters at the MSB so bit i lands in diff[i] after WIDTH shifts.
                diff_d            = diff_q >> 1;
                diff_d[WIDTH-1]   = d_bit;
                cnt_d             = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    bout_d  = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // d_bit is the result MSB on the final cycle.
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit);
`endif
                end
            end
            StDone: begin
                if (done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Handshake and status outputs decoded directly from state.
    always_comb begin
        start_ready = (state_q == StIdle);
        done_valid  = (state_q == StDone);
        busy        = (state_q == StRun);
        diff        = diff_q;
        bout        = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf         = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 main instance plus a WIDTH=1 instance.
// Build with SERIAL_SUB_OVF_EN defined to also check the ovf output.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid, start_ready;
    logic [7:0] a, b, diff;
    logic       bin, bout, done_valid, done_ready, busy;
    logic       ovf_obs;

    logic       sv1, sr1, a1, b1, bin1, d1, bout1, dv1, dr1, busy1;
    logic       ovf1_obs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .diff       (diff),
        .bout       (bout),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .busy       (busy)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf_obs)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start_valid(sv1),
        .start_ready(sr1),
        .a          (a1),
        .b          (b1),
        .bin        (bin1),
        .diff       (d1),
        .bout       (bout1),
        .done_valid (dv1),
        .done_ready (dr1),
        .busy       (busy1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf1_obs)
`endif
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_obs  = 1'b0;
    assign ovf1_obs = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Accept one operation, wait for done (bounded), check result; optionally release it.
    task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tbin, input logic [7:0] ed, input logic eb,
                         input logic eo, input logic release_it);
        int n;
        @(negedge clk);
        check({tag, "_ready"}, start_ready, 1);
        a = ta; b = tb_; bin = tbin; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = ~ta; b = ~tb_; bin = ~tbin;   // must be ignored after the accept edge
        check({tag, "_busy"}, busy, 1);
        n = 0;
        while (!done_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 8);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, ovf_obs, eo);
`endif
        if (release_it) begin
            @(negedge clk); done_ready = 1'b1;
            @(posedge clk); #1; done_ready = 1'b0;
            check({tag, "_idle_dv"}, done_valid, 0);
            check({tag, "_idle_diff"}, diff, ed);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start_valid = 0; a = 0; b = 0; bin = 0; done_ready = 0;
        sv1 = 0; a1 = 0; b1 = 0; bin1 = 0; dr1 = 0;
        #2;
        check("rst_ready", start_ready, 1);
        check("rst_dv", done_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        @(negedge clk); rst = 1'b0;

        do_op("basic", 8'h05, 8'h03, 0, 8'h02, 0, 0, 1);
        do_op("under", 8'h00, 8'h01, 0, 8'hFF, 1, 0, 1);
        do_op("bin1",  8'hFF, 8'hFF, 1, 8'hFF, 1, 0, 1);
        do_op("bin2",  8'h10, 8'h00, 1, 8'h0F, 0, 0, 1);
        do_op("ovf1",  8'h80, 8'h01, 0, 8'h7F, 0, 1, 1);

        // Backpressure: hold result, offer a new start that must wait.
        do_op("bp", 8'h33, 8'h11, 0, 8'h22, 0, 0, 0);
        @(negedge clk);
        a = 8'h01; b = 8'h02; bin = 0; start_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_dv", done_valid, 1);
            check("bp_sr", start_ready, 0);
            check("bp_diff", diff, 8'h22);
        end
        done_ready = 1'b1;
        @(posedge clk); #1; done_ready = 1'b0;
        check("bp_back_idle", start_ready, 1);
        @(posedge clk); #1;                // queued start accepted here
        start_valid = 1'b0;
        check("bp_q_busy", busy, 1);
        n = 0;
        while (!done_valid && n < 40) begin @(posedge clk); #1; n++; end
        check("bp_q_lat", n, 8);
        check("bp_q_diff", diff, 8'hFF);
        check("bp_q_bout", bout, 1);
        @(negedge clk); done_ready = 1'b1;
        @(posedge clk); #1; done_ready = 1'b0;

        // Reset in the middle of a run.
        @(negedge clk);
        a = 8'h55; b = 8'h12; bin = 0; start_valid = 1'b1;
        @(posedge clk); #1; start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mr_ready", start_ready, 1);
        check("mr_busy", busy, 0);
        check("mr_dv", done_valid, 0);
        check("mr_diff", diff, 0);
        check("mr_bout", bout, 0);
        @(negedge clk); rst = 1'b0;
        do_op("after_rst", 8'h0A, 8'h04, 0, 8'h06, 0, 0, 1);

        // WIDTH=1: 0 - 1 -> diff 1, borrow 1, one run cycle.
        @(negedge clk);
        a1 = 0; b1 = 1; bin1 = 0; sv1 = 1'b1;
        @(posedge clk); #1; sv1 = 1'b0;
        check("w1_busy", busy1, 1);
        n = 0;
        while (!dv1 && n < 10) begin @(posedge clk); #1; n++; end
        check("w1_lat", n, 1);
        check("w1_diff", d1, 1);
        check("w1_bout", bout1, 1);
`ifdef SERIAL_SUB_OVF_EN
        check("w1_ovf", ovf1_obs, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 1..32).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port start_valid, input, 1, operands and borrow-in are valid.
REQ-005 The module SHALL have port start_ready, output, 1, the block can accept operands.
REQ-006 The module SHALL have ports a and b, input, WIDTH each, minuend and subtrahend.
REQ-007 The module SHALL have port bin, input, 1, borrow-in.
REQ-008 The module SHALL have port diff, output, WIDTH, the result a - b - bin modulo 2^WIDTH.
REQ-009 The module SHALL have port bout, output, 1, the final borrow-out.
REQ-010 The module SHALL have port done_valid, output, 1, diff and bout are valid.
REQ-011 The module SHALL have port done_ready, input, 1, the consumer accepts the result.
REQ-012 The module SHALL have port busy, output, 1, high in RUN.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; start_ready SHALL be 1 only in IDLE, and done_valid SHALL be 1 only in DONE.
REQ-014 In IDLE, on an edge with start_valid=1, the block SHALL latch a, b and bin, clear the bit counter and enter RUN; inputs SHALL be ignored outside this accept edge.
REQ-015 In RUN, each cycle SHALL process one bit i, LSB first, with the full-subtractor equations d = a[i]^b[i]^br and br' = (~a[i]&b[i]) | (~(a[i]^b[i])&br); br starts at the latched bin.
REQ-016 Each result bit SHALL shift into a diff register from the MSB side, so that after WIDTH bits diff[i] holds bit i.
REQ-017 After exactly WIDTH RUN cycles the block SHALL enter DONE with bout equal to the final br; done_valid SHALL rise WIDTH edges after the accept edge.
REQ-018 In DONE, diff, bout and done_valid SHALL hold stable until done_ready=1; on that edge the block SHALL return to IDLE.
REQ-019 start_valid asserted during RUN or DONE SHALL have no effect and SHALL NOT be latched; the source holds it until start_ready is 1.
REQ-020 diff and bout SHALL remain valid in IDLE until the next accept edge, but done_valid SHALL be 0 in IDLE.
REQ-021 With WIDTH=1, RUN SHALL last exactly one cycle.
REQ-022 The bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-023 While rst=1, the state SHALL be IDLE, and diff, bout, done_valid, busy, the counter and the borrow register SHALL be 0, with start_ready=1, independent of clk.
REQ-024 Reset asserted during RUN or DONE SHALL abort the operation with no result presented; the first accept after rst deasserts SHALL start a fresh operation.

Configuration
REQ-025 When macro SERIAL_SUB_OVF_EN is defined, the block SHALL add output ovf (1 bit), the signed overflow of a - b - bin, computed as (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]); ovf SHALL be valid with done_valid, reset to 0 and hold like diff.
REQ-026 When SERIAL_SUB_OVF_EN is undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Basic: WIDTH=8, a=8'h05, b=8'h03, bin=0 -> diff=8'h02, bout=0, done_valid high exactly 8 edges after the accept edge.
REQ-028 Underflow: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1.
REQ-029 Borrow-in: a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1; then a=8'h10, b=8'h00, bin=1 -> diff=8'h0F, bout=0.
REQ-030 Backpressure: hold done_ready=0 for 5 cycles in DONE -> outputs stable and start_ready=0 throughout; a new start_valid is not accepted until done_ready is asserted, after which the block returns to IDLE.
REQ-031 Reset mid-RUN: assert rst after 3 bit cycles -> all outputs 0 and start_ready=1 immediately; the next operation 8'h0A-8'h04 gives 8'h06.
REQ-032 With SERIAL_SUB_OVF_EN defined: a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, ovf=1; a=8'h05, b=8'h03 -> ovf=0.
